// File: rtl/glb_iact_bank_pkg.sv
// Shared types and sizing helpers for the input-activation GLB bank.
// Holds the bank FSM encoding and the plane-size / fill-counter width functions.
package glb_iact_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_READY = 2'd2
   } bank_state_e;

   function automatic int iact_words(input int act_size);
      return act_size * act_size;
   endfunction

   function automatic int fill_cnt_width(input int words);
      return $clog2(words + 1);
   endfunction

endpackage

// File: rtl/glb_iact_bank_if.sv
// Loader fill port plus west-router read port of the iact GLB bank.
// The bank side uses the slave modport; loader/router models use master.
interface glb_iact_bank_if #(
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10
);
   logic [DATA_BITWIDTH-1:0]     fill_data_i;
   logic                         fill_valid_i;
   logic                         fill_ready_o;
   logic                         clear_i;
   logic [ADDR_BITWIDTH_GLB-1:0] west_addr_read;
   logic                         west_req_read;
   logic [DATA_BITWIDTH-1:0]     west_data_i;
   logic                         west_enable_i;
   logic                         bank_ready_o;
   logic                         range_err_o;

   modport master (
      output fill_data_i, fill_valid_i, clear_i, west_addr_read, west_req_read,
      input  fill_ready_o, west_data_i, west_enable_i, bank_ready_o, range_err_o
   );

   modport slave (
      input  fill_data_i, fill_valid_i, clear_i, west_addr_read, west_req_read,
      output fill_ready_o, west_data_i, west_enable_i, bank_ready_o, range_err_o
   );
endinterface

// File: rtl/glb_sram_2p.sv
// Simple dual-port array: one write port, one synchronous read port (1-cycle latency).
module glb_sram_2p #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array and its read register carry no reset so they map onto SRAM macros.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/glb_iact_bank.sv
// Input-activation GLB bank: loader fills one plane, then the west router reads it back.
// Early reads are parked in a one-entry pending slot until the plane is complete.
module glb_iact_bank
   import glb_iact_bank_pkg::*;
#(
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int act_size          = 5,
   parameter int A_READ_ADDR       = 100
) (
   input  logic            clk,
   input  logic            reset,
   glb_iact_bank_if.slave  bus
);
   localparam int DW         = DATA_BITWIDTH;
   localparam int AW         = ADDR_BITWIDTH_GLB;
   localparam int IACT_WORDS = iact_words(act_size);
   localparam int CNT_W      = fill_cnt_width(IACT_WORDS);

   localparam logic [AW-1:0]    BASE     = AW'(A_READ_ADDR);
   localparam logic [AW-1:0]    WORDS_A  = AW'(IACT_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IACT_WORDS - 1);

   bank_state_e      state_q, state_d;
   logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
   logic             pend_vld_q, pend_vld_d;
   logic [AW-1:0]    pend_addr_q, pend_addr_d;
   logic             skid_vld_q, skid_vld_d;
   logic [AW-1:0]    skid_addr_q, skid_addr_d;
   logic             rd_vld_q, rd_vld_d;
   logic             rd_oor_q, rd_oor_d;
   logic             range_err_q, range_err_d;

   logic             fill_ready, fill_acc, rd_issue;
   logic [AW-1:0]    rd_addr, rd_off, wr_addr;
   logic [DW-1:0]    sram_rdata;

   assign fill_ready = (state_q != ST_READY);
   assign fill_acc   = bus.fill_valid_i & fill_ready & ~bus.clear_i;
   assign wr_addr    = BASE + AW'(fill_cnt_q);

   // NOTE: every variable gets its default first, so no branch can infer a latch.
   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      skid_vld_d  = skid_vld_q;
      skid_addr_d = skid_addr_q;
      range_err_d = range_err_q;
      rd_issue    = 1'b0;
      rd_addr     = bus.west_addr_read;

      if (fill_acc) begin
         fill_cnt_d = fill_cnt_q + CNT_W'(1);
         state_d    = (fill_cnt_q == LAST_CNT) ? ST_READY : ST_FILL;
      end

      // Oldest request first: pending slot, then skid, then the live request.
      if (state_q == ST_READY) begin
         if (pend_vld_q || skid_vld_q) begin
            rd_issue    = 1'b1;
            rd_addr     = pend_vld_q ? pend_addr_q : skid_addr_q;
            pend_vld_d  = 1'b0;
            skid_vld_d  = bus.west_req_read;
            skid_addr_d = bus.west_addr_read;
         end else begin
            rd_issue = bus.west_req_read;
         end
      end else if (bus.west_req_read && !pend_vld_q) begin
         pend_vld_d  = 1'b1;
         pend_addr_d = bus.west_addr_read;
      end

      rd_off   = rd_addr - BASE;
      rd_oor_d = (rd_off >= WORDS_A);
      rd_vld_d = rd_issue;
      if (rd_issue && rd_oor_d) range_err_d = 1'b1;

      if (bus.clear_i) begin
         state_d     = ST_IDLE;
         fill_cnt_d  = '0;
         pend_vld_d  = 1'b0;
         skid_vld_d  = 1'b0;
         range_err_d = 1'b0;
         rd_vld_d    = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         fill_cnt_q  <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_addr_q <= '0;
         rd_vld_q    <= 1'b0;
         rd_oor_q    <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         skid_vld_q  <= skid_vld_d;
         skid_addr_q <= skid_addr_d;
         rd_vld_q    <= rd_vld_d;
         rd_oor_q    <= rd_oor_d;
         range_err_q <= range_err_d;
      end
   end

   glb_sram_2p #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) u_sram (
      .clk   (clk),
      .we    (fill_acc),
      .waddr (wr_addr),
      .wdata (bus.fill_data_i),
      .re    (rd_issue),
      .raddr (rd_addr),
      .rdata (sram_rdata)
   );

   assign bus.fill_ready_o  = fill_ready;
   assign bus.bank_ready_o  = (state_q == ST_READY);
   assign bus.range_err_o   = range_err_q;
   assign bus.west_enable_i = rd_vld_q;
   assign bus.west_data_i   = (rd_vld_q && !rd_oor_q) ? sram_rdata : '0;
endmodule

// File: tb/tb_glb_iact_bank.sv
// Self-checking bench for glb_iact_bank: randomized fills/reads against an address-level plane model.
module tb_glb_iact_bank;
   localparam int DW     = 16;
   localparam int AW     = 10;
   localparam int DEPTH  = 1024;
   localparam int WORDS  = 25;
   localparam int BASE_A = 100;
   localparam int BASE_B = 1020;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   glb_iact_bank_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW)) bus_a ();
   glb_iact_bank_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW)) bus_b ();

   glb_iact_bank #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .act_size(5), .A_READ_ADDR(BASE_A))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   glb_iact_bank #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .act_size(5), .A_READ_ADDR(BASE_B))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: bank contents by address, words loaded so far, sticky error.
   logic [DW-1:0] mem_a [DEPTH];
   logic [DW-1:0] mem_b [DEPTH];
   int            cnt_a;
   bit            err_a;

   function automatic bit in_plane(input int base, input int addr);
      return ((addr - base + DEPTH) % DEPTH) < WORDS;
   endfunction

   function automatic logic [DW-1:0] exp_a(input int addr);
      return in_plane(BASE_A, addr) ? mem_a[addr] : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_a(input bit seq, input int n);
      logic [DW-1:0] v;
      for (int i = 0; i < n; i++) begin
         v = seq ? DW'(cnt_a + 1) : DW'($urandom);
         bus_a.fill_valid_i = 1'b1;
         bus_a.fill_data_i  = v;
         tick();
         if (cnt_a < WORDS) begin
            mem_a[(BASE_A + cnt_a) % DEPTH] = v;
            cnt_a++;
         end
      end
      bus_a.fill_valid_i = 1'b0;
   endtask

   task automatic clear_a();
      bus_a.clear_i = 1'b1;
      tick();
      bus_a.clear_i = 1'b0;
      cnt_a = 0;
      err_a = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      cnt_a = 0;
      err_a = 1'b0;
      n_total++; if (bus_a.fill_ready_o !== 1'b1) $display("FAIL rst_fill_ready got %b want 1", bus_a.fill_ready_o); else n_pass++;
      n_total++; if (bus_a.bank_ready_o !== 1'b0) $display("FAIL rst_bank_ready got %b want 0", bus_a.bank_ready_o); else n_pass++;
      n_total++; if (bus_a.west_enable_i !== 1'b0) $display("FAIL rst_enable got %b want 0", bus_a.west_enable_i); else n_pass++;
      n_total++; if (bus_a.west_data_i !== '0) $display("FAIL rst_data got %h want 0", bus_a.west_data_i); else n_pass++;
      n_total++; if (bus_a.range_err_o !== 1'b0) $display("FAIL rst_range_err got %b want 0", bus_a.range_err_o); else n_pass++;
      n_total++; if (bus_b.fill_ready_o !== 1'b1) $display("FAIL rst_b_fill_ready got %b want 1", bus_b.fill_ready_o); else n_pass++;
   endtask

   task automatic test_fill_read();
      fill_a(1'b1, WORDS - 1);
      n_total++; if (bus_a.bank_ready_o !== 1'b0 || bus_a.fill_ready_o !== 1'b1)
         $display("FAIL fill24_flags got ready=%b fill_ready=%b want 0/1", bus_a.bank_ready_o, bus_a.fill_ready_o); else n_pass++;
      fill_a(1'b1, 1);
      n_total++; if (bus_a.bank_ready_o !== 1'b1) $display("FAIL fill25_bank_ready got %b want 1", bus_a.bank_ready_o); else n_pass++;
      n_total++; if (bus_a.fill_ready_o !== 1'b0) $display("FAIL fill25_fill_ready got %b want 0", bus_a.fill_ready_o); else n_pass++;
      for (int i = 0; i < WORDS; i++) begin
         bus_a.west_req_read  = 1'b1;
         bus_a.west_addr_read = AW'(BASE_A + i);
         tick();
         n_total++; if (bus_a.west_enable_i !== 1'b1 || bus_a.west_data_i !== exp_a(BASE_A + i))
            $display("FAIL seq_read[%0d] got en=%b data=%h want en=1 data=%h", i, bus_a.west_enable_i, bus_a.west_data_i, exp_a(BASE_A + i));
         else n_pass++;
      end
      bus_a.west_req_read = 1'b0;
      tick();
      n_total++; if (bus_a.west_enable_i !== 1'b0 || bus_a.west_data_i !== '0)
         $display("FAIL seq_read_idle got en=%b data=%h want 0/0", bus_a.west_enable_i, bus_a.west_data_i); else n_pass++;
   endtask

   task automatic test_random_reads(input int n);
      bit r;
      int addr;
      for (int c = 0; c < n; c++) begin
         r    = ($urandom % 4) != 0;
         addr = (($urandom % 4) != 0) ? BASE_A + int'($urandom % WORDS) : int'($urandom % DEPTH);
         bus_a.west_req_read  = r;
         bus_a.west_addr_read = AW'(addr);
         tick();
         if (r && !in_plane(BASE_A, addr)) err_a = 1'b1;
         n_total++; if (bus_a.west_enable_i !== r || bus_a.west_data_i !== (r ? exp_a(addr) : '0))
            $display("FAIL rand_read[%0d] addr=%0d got en=%b data=%h want en=%b data=%h", c, addr,
                     bus_a.west_enable_i, bus_a.west_data_i, r, r ? exp_a(addr) : '0);
         else n_pass++;
         n_total++; if (bus_a.range_err_o !== err_a)
            $display("FAIL rand_range_err[%0d] got %b want %b", c, bus_a.range_err_o, err_a); else n_pass++;
      end
      bus_a.west_req_read = 1'b0;
   endtask

   task automatic test_out_of_range();
      bus_a.west_req_read  = 1'b1;
      bus_a.west_addr_read = AW'(130);
      tick();
      bus_a.west_req_read  = 1'b0;
      n_total++; if (bus_a.west_enable_i !== 1'b1 || bus_a.west_data_i !== '0)
         $display("FAIL oor_read got en=%b data=%h want 1/0", bus_a.west_enable_i, bus_a.west_data_i); else n_pass++;
      n_total++; if (bus_a.range_err_o !== 1'b1) $display("FAIL oor_err got %b want 1", bus_a.range_err_o); else n_pass++;
      repeat (3) tick();
      n_total++; if (bus_a.range_err_o !== 1'b1 || bus_a.west_enable_i !== 1'b0)
         $display("FAIL oor_sticky got err=%b en=%b want 1/0", bus_a.range_err_o, bus_a.west_enable_i); else n_pass++;
      clear_a();
      n_total++; if (bus_a.range_err_o !== 1'b0) $display("FAIL clear_err got %b want 0", bus_a.range_err_o); else n_pass++;
      n_total++; if (bus_a.bank_ready_o !== 1'b0 || bus_a.fill_ready_o !== 1'b1)
         $display("FAIL clear_state got ready=%b fill_ready=%b want 0/1", bus_a.bank_ready_o, bus_a.fill_ready_o); else n_pass++;
   endtask

   task automatic test_pending();
      int pulses;
      for (int i = 0; i < WORDS; i++) begin
         bus_a.fill_valid_i   = 1'b1;
         bus_a.fill_data_i    = DW'(i + 1);
         bus_a.west_req_read  = (i == 5) || (i == 9);
         bus_a.west_addr_read = (i == 5) ? AW'(102) : AW'(115);
         tick();
         mem_a[BASE_A + i] = DW'(i + 1);
         n_total++; if (bus_a.west_enable_i !== 1'b0) $display("FAIL pend_early_pulse[%0d] got %b want 0", i, bus_a.west_enable_i); else n_pass++;
      end
      cnt_a = WORDS;
      bus_a.fill_valid_i  = 1'b0;
      bus_a.west_req_read = 1'b0;
      n_total++; if (bus_a.bank_ready_o !== 1'b1 || bus_a.west_enable_i !== 1'b0)
         $display("FAIL pend_first_ready got ready=%b en=%b want 1/0", bus_a.bank_ready_o, bus_a.west_enable_i); else n_pass++;
      tick();
      n_total++; if (bus_a.west_enable_i !== 1'b1 || bus_a.west_data_i !== DW'(3))
         $display("FAIL pend_serve got en=%b data=%h want 1/0003", bus_a.west_enable_i, bus_a.west_data_i); else n_pass++;
      pulses = 0;
      repeat (4) begin
         tick();
         if (bus_a.west_enable_i === 1'b1) pulses++;
      end
      n_total++; if (pulses != 0) $display("FAIL pend_extra_pulses got %0d want 0", pulses); else n_pass++;
      clear_a();
   endtask

   task automatic test_pending_skid();
      bus_a.west_req_read  = 1'b1;
      bus_a.west_addr_read = AW'(102);
      tick();
      bus_a.west_req_read  = 1'b0;
      n_total++; if (bus_a.west_enable_i !== 1'b0 || bus_a.bank_ready_o !== 1'b0)
         $display("FAIL idle_req got en=%b ready=%b want 0/0", bus_a.west_enable_i, bus_a.bank_ready_o); else n_pass++;
      fill_a(1'b1, WORDS);
      bus_a.west_req_read  = 1'b1;
      bus_a.west_addr_read = AW'(110);
      tick();
      bus_a.west_req_read  = 1'b0;
      n_total++; if (bus_a.west_enable_i !== 1'b1 || bus_a.west_data_i !== DW'(3))
         $display("FAIL skid_first got en=%b data=%h want 1/0003", bus_a.west_enable_i, bus_a.west_data_i); else n_pass++;
      tick();
      n_total++; if (bus_a.west_enable_i !== 1'b1 || bus_a.west_data_i !== DW'(11))
         $display("FAIL skid_second got en=%b data=%h want 1/000b", bus_a.west_enable_i, bus_a.west_data_i); else n_pass++;
      tick();
      n_total++; if (bus_a.west_enable_i !== 1'b0) $display("FAIL skid_done got %b want 0", bus_a.west_enable_i); else n_pass++;
   endtask

   task automatic test_clear_inflight();
      bus_a.west_req_read  = 1'b1;
      bus_a.west_addr_read = AW'(101);
      tick();
      n_total++; if (bus_a.west_enable_i !== 1'b1 || bus_a.west_data_i !== exp_a(101))
         $display("FAIL inflight_pulse got en=%b data=%h want 1/%h", bus_a.west_enable_i, bus_a.west_data_i, exp_a(101)); else n_pass++;
      bus_a.west_addr_read = AW'(103);
      clear_a();
      bus_a.west_req_read = 1'b0;
      n_total++; if (bus_a.west_enable_i !== 1'b0 || bus_a.west_data_i !== '0)
         $display("FAIL inflight_dropped got en=%b data=%h want 0/0", bus_a.west_enable_i, bus_a.west_data_i); else n_pass++;
      n_total++; if (bus_a.bank_ready_o !== 1'b0) $display("FAIL inflight_state got %b want 0", bus_a.bank_ready_o); else n_pass++;
   endtask

   task automatic test_clear_fill_collision();
      fill_a(1'b0, 3);
      bus_a.fill_valid_i = 1'b1;
      bus_a.fill_data_i  = 16'hdead;
      clear_a();
      bus_a.fill_valid_i = 1'b0;
      fill_a(1'b0, WORDS - 1);
      n_total++; if (bus_a.bank_ready_o !== 1'b0 || bus_a.fill_ready_o !== 1'b1)
         $display("FAIL collide_24 got ready=%b fill_ready=%b want 0/1", bus_a.bank_ready_o, bus_a.fill_ready_o); else n_pass++;
      fill_a(1'b0, 1);
      n_total++; if (bus_a.bank_ready_o !== 1'b1) $display("FAIL collide_25 got %b want 1", bus_a.bank_ready_o); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         bus_a.west_req_read  = 1'b1;
         bus_a.west_addr_read = AW'(BASE_A + i);
         tick();
         n_total++; if (bus_a.west_data_i !== exp_a(BASE_A + i))
            $display("FAIL collide_read[%0d] got %h want %h", i, bus_a.west_data_i, exp_a(BASE_A + i)); else n_pass++;
      end
      bus_a.west_req_read = 1'b0;
   endtask

   task automatic test_reset_midfill();
      clear_a();
      fill_a(1'b0, 10);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cnt_a = 0;
      err_a = 1'b0;
      n_total++; if (bus_a.fill_ready_o !== 1'b1 || bus_a.bank_ready_o !== 1'b0 || bus_a.west_enable_i !== 1'b0)
         $display("FAIL midfill_rst got fill_ready=%b ready=%b en=%b want 1/0/0",
                  bus_a.fill_ready_o, bus_a.bank_ready_o, bus_a.west_enable_i); else n_pass++;
      fill_a(1'b0, WORDS - 1);
      n_total++; if (bus_a.bank_ready_o !== 1'b0) $display("FAIL refill_24 got %b want 0", bus_a.bank_ready_o); else n_pass++;
      fill_a(1'b0, 1);
      n_total++; if (bus_a.bank_ready_o !== 1'b1) $display("FAIL refill_25 got %b want 1", bus_a.bank_ready_o); else n_pass++;
      test_random_reads(60);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < WORDS; i++) begin
         bus_b.fill_valid_i = 1'b1;
         bus_b.fill_data_i  = DW'(i + 1);
         tick();
         mem_b[(BASE_B + i) % DEPTH] = DW'(i + 1);
      end
      bus_b.fill_valid_i = 1'b0;
      n_total++; if (bus_b.bank_ready_o !== 1'b1) $display("FAIL wrap_ready got %b want 1", bus_b.bank_ready_o); else n_pass++;
      bus_b.west_req_read  = 1'b1;
      bus_b.west_addr_read = AW'(0);
      tick();
      n_total++; if (bus_b.west_enable_i !== 1'b1 || bus_b.west_data_i !== mem_b[0] || bus_b.range_err_o !== 1'b0)
         $display("FAIL wrap_addr0 got en=%b data=%h err=%b want 1/%h/0", bus_b.west_enable_i, bus_b.west_data_i,
                  bus_b.range_err_o, mem_b[0]); else n_pass++;
      bus_b.west_addr_read = AW'(1020);
      tick();
      n_total++; if (bus_b.west_data_i !== mem_b[1020] || bus_b.range_err_o !== 1'b0)
         $display("FAIL wrap_addr1020 got data=%h err=%b want %h/0", bus_b.west_data_i, bus_b.range_err_o, mem_b[1020]); else n_pass++;
      bus_b.west_addr_read = AW'(1019);
      tick();
      bus_b.west_req_read  = 1'b0;
      n_total++; if (bus_b.west_enable_i !== 1'b1 || bus_b.west_data_i !== '0 || bus_b.range_err_o !== 1'b1)
         $display("FAIL wrap_oor got en=%b data=%h err=%b want 1/0/1", bus_b.west_enable_i, bus_b.west_data_i,
                  bus_b.range_err_o); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      bus_a.fill_data_i = '0; bus_a.fill_valid_i = 1'b0; bus_a.clear_i = 1'b0;
      bus_a.west_addr_read = '0; bus_a.west_req_read = 1'b0;
      bus_b.fill_data_i = '0; bus_b.fill_valid_i = 1'b0; bus_b.clear_i = 1'b0;
      bus_b.west_addr_read = '0; bus_b.west_req_read = 1'b0;

      test_reset();
      test_fill_read();
      test_random_reads(200);
      test_out_of_range();
      test_pending();
      test_pending_skid();
      test_clear_inflight();
      test_clear_fill_collision();
      test_reset_midfill();
      test_wrap();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached after %0d/%0d checks", n_pass, n_total);
      $fatal(1);
   end
endmodule
